// File: rtl/keypad_scan_pkg.sv
// Shared types, key codes and the row/column-to-code map for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Code printed on the key at row r, column c.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

  // Index of the lowest active-low column; only meaningful when col != 4'hF.
  function automatic logic [1:0] first_low(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0])      idx = 2'd0;
    else if (!col[1]) idx = 2'd1;
    else if (!col[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the debounced key report towards the player controller.
interface keypad_scan_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_pressed;
  logic [3:0] key_value;
  logic       key_strobe;

  modport master (
    input  col_in,
    output row_out,
    output key_pressed,
    output key_value,
    output key_strobe
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_pressed,
    input  key_value,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

  logic [TW-1:0] div_q;

  assign tick = (div_q == LAST);

  // Count 0..SCAN_DIV-1 and wrap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) div_q <= '0;
    else if (tick)  div_q <= '0;
    else            div_q <= div_q + TW'(1);
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row rotation, column sync, press/release debounce.
//   state    | meaning
//   SCAN     | rotating rows, waiting for any low column
//   DEBOUNCE | candidate key seen, counting stable low ticks
//   PRESSED  | key accepted and held, row frozen
//   RELEASE  | column went high, counting stable high ticks
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  keypad_scan_if.master kp
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic            tick;
  logic [3:0]      col_s1_q, col_s_q;
  kp_state_e       state_q;
  logic [1:0]      row_q, col_q;
  logic [3:0]      row_out_q;
  logic [CW-1:0]   cnt_q;
  logic            key_pressed_q, key_strobe_q;
  logic [3:0]      key_value_q;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tick      (tick)
  );

  // Two-flop synchronizer; idle columns are pulled up, so reset to all-high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_s1_q <= 4'hF;
      col_s_q  <= 4'hF;
    end else begin
      col_s1_q <= kp.col_in;
      col_s_q  <= col_s1_q;
    end
  end

  // Scan/debounce FSM; acts only on tick cycles, strobe self-clears otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= SCAN;
      row_q         <= 2'd0;
      row_out_q     <= 4'b1110;
      col_q         <= 2'd0;
      cnt_q         <= '0;
      key_pressed_q <= 1'b0;
      key_value_q   <= 4'h0;
      key_strobe_q  <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (col_s_q != 4'hF) begin
              col_q <= first_low(col_s_q);
              if (DEBOUNCE_TICKS == 1) begin
                key_value_q   <= key_code(row_q, first_low(col_s_q));
                key_pressed_q <= 1'b1;
                key_strobe_q  <= 1'b1;
                cnt_q         <= '0;
                state_q       <= PRESSED;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= DEBOUNCE;
              end
            end else begin
              row_q     <= row_q + 2'd1;
              row_out_q <= {row_out_q[2:0], row_out_q[3]};
            end
          end
          DEBOUNCE: begin
            if (!col_s_q[col_q]) begin
              if (cnt_q == CNT_LAST) begin
                key_value_q   <= key_code(row_q, col_q);
                key_pressed_q <= 1'b1;
                key_strobe_q  <= 1'b1;
                cnt_q         <= '0;
                state_q       <= PRESSED;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              // Glitch, not a press: move on without touching the outputs.
              row_q     <= row_q + 2'd1;
              row_out_q <= {row_out_q[2:0], row_out_q[3]};
              cnt_q     <= '0;
              state_q   <= SCAN;
            end
          end
          PRESSED: begin
            if (col_s_q[col_q]) begin
              if (DEBOUNCE_TICKS == 1) begin
                key_pressed_q <= 1'b0;
                row_q         <= row_q + 2'd1;
                row_out_q     <= {row_out_q[2:0], row_out_q[3]};
                cnt_q         <= '0;
                state_q       <= SCAN;
              end else begin
                cnt_q   <= CW'(1);
                state_q <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (col_s_q[col_q]) begin
              if (cnt_q == CNT_LAST) begin
                key_pressed_q <= 1'b0;
                row_q         <= row_q + 2'd1;
                row_out_q     <= {row_out_q[2:0], row_out_q[3]};
                cnt_q         <= '0;
                state_q       <= SCAN;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              // Release bounce: still held, no new strobe.
              cnt_q   <= '0;
              state_q <= PRESSED;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign kp.row_out     = row_out_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.key_value   = key_value_q;
  assign kp.key_strobe  = key_strobe_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_TICKS=3.
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;

  logic clk;
  logic rst_n;
  logic held [4][4];
  logic [3:0] col_v;
  int n_chk;
  int n_fail;
  int strobe_cnt;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(3)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .kp        (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row_out[r] && held[r][c]) col_v[c] = 1'b0;
  end
  assign kif.col_in = col_v;

  always @(negedge clk) if (kif.key_strobe) strobe_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n scan ticks; lands 1ns after the tick edge.
  task automatic step(input int n);
    repeat (n * SCAN_DIV) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; strobe_cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) held[r][c] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_row", kif.row_out, 4'b1110);
    chk("rst_pressed", kif.key_pressed, 0);
    chk("rst_value", kif.key_value, 4'h0);
    chk("rst_strobe", kif.key_strobe, 0);
    rst_n = 1'b1;

    // 1: idle rotation
    step(1); chk("scan_r1", kif.row_out, 4'b1101);
    step(1); chk("scan_r2", kif.row_out, 4'b1011);
    step(1); chk("scan_r3", kif.row_out, 4'b0111);
    step(1); chk("scan_r0", kif.row_out, 4'b1110);
    chk("scan_pressed", kif.key_pressed, 0);

    // 2: key 6 (r1,c2)
    held[1][2] = 1'b1;
    step(3);
    chk("k6_pre_pressed", kif.key_pressed, 0);
    chk("k6_pre_row", kif.row_out, 4'b1101);
    step(1);
    chk("k6_pressed", kif.key_pressed, 1);
    chk("k6_value", kif.key_value, 4'h6);
    chk("k6_strobe_hi", kif.key_strobe, 1);
    @(posedge clk); #1;
    chk("k6_strobe_lo", kif.key_strobe, 0);
    repeat (SCAN_DIV - 1) @(posedge clk);
    #1;
    step(15);
    chk("k6_hold_row", kif.row_out, 4'b1101);
    chk("k6_hold_pressed", kif.key_pressed, 1);
    chk("k6_strobes", strobe_cnt, 1);
    held[1][2] = 1'b0;
    step(2); chk("k6_rel_wait", kif.key_pressed, 1);
    step(1);
    chk("k6_released", kif.key_pressed, 0);
    chk("k6_rel_row", kif.row_out, 4'b1011);
    chk("k6_keep_value", kif.key_value, 4'h6);

    // 3: key 8 (r2,c1) with press bounce
    held[2][1] = 1'b1; step(1);
    held[2][1] = 1'b0; step(1);
    chk("k8_bounce_row", kif.row_out, 4'b0111);
    held[2][1] = 1'b1;
    step(5);
    chk("k8_pre_pressed", kif.key_pressed, 0);
    chk("k8_pre_strobes", strobe_cnt, 1);
    step(1);
    chk("k8_pressed", kif.key_pressed, 1);
    chk("k8_value", kif.key_value, 4'h8);
    held[2][1] = 1'b0;
    step(3);
    chk("k8_released", kif.key_pressed, 0);
    chk("k8_strobes", strobe_cnt, 2);
    chk("k8_rel_row", kif.row_out, 4'b0111);

    // 4: key A (r0,c3) with release bounce
    held[0][3] = 1'b1;
    step(4);
    chk("kA_pressed", kif.key_pressed, 1);
    chk("kA_value", kif.key_value, 4'hA);
    held[0][3] = 1'b0; step(2);
    chk("kA_bounce1", kif.key_pressed, 1);
    held[0][3] = 1'b1; step(1);
    chk("kA_bounce2", kif.key_pressed, 1);
    held[0][3] = 1'b0; step(2);
    chk("kA_bounce3", kif.key_pressed, 1);
    step(1);
    chk("kA_released", kif.key_pressed, 0);
    chk("kA_keep_value", kif.key_value, 4'hA);
    chk("kA_strobes", strobe_cnt, 3);
    chk("kA_rel_row", kif.row_out, 4'b1101);

    // 5: '*' and '#' together on row 3
    held[3][0] = 1'b1; held[3][2] = 1'b1;
    step(5);
    chk("star_pressed", kif.key_pressed, 1);
    chk("star_value", kif.key_value, 4'hE);
    held[3][0] = 1'b0;
    step(3);
    chk("star_released", kif.key_pressed, 0);
    chk("star_strobes", strobe_cnt, 4);
    chk("star_rel_row", kif.row_out, 4'b1110);
    step(5);
    chk("hash_pre_pressed", kif.key_pressed, 0);
    step(1);
    chk("hash_pressed", kif.key_pressed, 1);
    chk("hash_value", kif.key_value, 4'hF);

    // 6: reset while PRESSED, key still held
    step(2);
    rst_n = 1'b0; #1;
    chk("mrst_row", kif.row_out, 4'b1110);
    chk("mrst_pressed", kif.key_pressed, 0);
    chk("mrst_value", kif.key_value, 4'h0);
    chk("mrst_strobe", kif.key_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk("reacc_pre_pressed", kif.key_pressed, 0);
    step(1);
    chk("reacc_pressed", kif.key_pressed, 1);
    chk("reacc_value", kif.key_value, 4'hF);
    step(1);
    chk("reacc_strobes", strobe_cnt, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and debounces it, using the 100 MHz system clock.
- Feeds the music player/organ controller with `key_pressed` (its IsPressed input) and `key_value` (its 4-bit keyboard_data input).
- Drives the rows active-low one at a time and samples the pulled-up columns.
- Reports one debounced key at a time, with a level "held" flag plus a one-cycle press strobe.

Parameters:
- SCAN_DIV, 100000: sys_clk cycles per scan tick (1 ms at 100 MHz); must be >= 2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks needed to accept a press or a release; must be >= 1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- col_in  in  4  keypad columns; active-low; asynchronous to sys_clk.
- row_out  out  4  keypad rows; active-low; exactly one bit is low at any time.
- key_pressed  out  1  level; high while a debounced key is held.
- key_value  out  4  code of the current or last accepted key.
- key_strobe  out  1  one-cycle pulse on each accepted press.

Behaviour:
- Reset values: row_out = 4'b1110 (row 0 driven), key_pressed = 0, key_value = 4'h0, key_strobe = 0, state = SCAN, all counters = 0.
- Reset mid-operation returns to these values immediately (asynchronous).
- Column synchronizer:
  - col_in passes through a 2-FF synchronizer; all decisions use the synchronized value col_s.
  - Input-to-decision latency is 2 cycles plus alignment to the next tick.
- Tick generator:
  - A counter runs 0..SCAN_DIV-1 and tick pulses for one cycle when it wraps.
  - The FSM acts only on tick cycles.
- Key map, row r (0..3) by column c (0..3):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- Column priority: when several columns are low, the lowest index c wins. Other rows are not examined while a key is tracked, so at most one key is reported.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE. A 2-bit state is sufficient.
- SCAN, on each tick:
  - If col_s != 4'hF: latch r and c, set cnt = 1, go to DEBOUNCE. If DEBOUNCE_TICKS == 1, go directly to accept instead.
  - Otherwise rotate row_out to the next row (3 wraps to 0).
  - Because rows change on a tick and are sampled on the next tick, every row gets one full tick period to settle.
- DEBOUNCE, on each tick:
  - If col_s[c] == 0: cnt++. When cnt reaches DEBOUNCE_TICKS, accept.
  - If col_s[c] == 1: abandon, rotate the row, return to SCAN. No output change.
- Accept (single cycle):
  - key_value <= code(r, c), key_pressed <= 1, key_strobe <= 1 for exactly that cycle.
  - Go to PRESSED.
  - key_value and key_pressed update in the same cycle.
- PRESSED, on each tick:
  - If col_s[c] == 1: cnt = 1, go to RELEASE.
  - Otherwise stay; row_out is held.
- RELEASE, on each tick:
  - If col_s[c] == 1: cnt++. When cnt reaches DEBOUNCE_TICKS: key_pressed <= 0, rotate the row, go to SCAN.
  - If col_s[c] == 0 (bounce): return to PRESSED with no new strobe and key_pressed still 1.
- Held-key rules:
  - key_value is stable from accept until the next accept, and is retained after release.
  - A second key pressed while one is held is ignored, even if it is in the same row.
- Minimum press latency: DEBOUNCE_TICKS ticks after the first low sample.
- A press is accepted once; repeat requires a release.
- Counter widths: the tick counter is $clog2(SCAN_DIV) bits; cnt is $clog2(DEBOUNCE_TICKS+1) bits. No overflow is possible.

Decomposition:
- Shared package keypad_pkg:
  - State encodings SCAN, DEBOUNCE, PRESSED, RELEASE.
  - Key code constants KEY_A = 4'hA, KEY_B, KEY_C, KEY_D, KEY_STAR = 4'hE, KEY_HASH = 4'hF.
  - The 16-entry row/col-to-code map as a constant function.
- Sub-module keypad_tick_gen (parameter SCAN_DIV; ports sys_clk, sys_rst_n, tick).
- The synchronizer and FSM stay in keypad_scan.

Test Plan:
All scenarios use SCAN_DIV = 4 and DEBOUNCE_TICKS = 3.
1. Reset, no key held: row_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per tick (every 4 cycles); key_pressed stays 0.
2. Hold key "6" (col_in[2] low only while row_out = 1101) for 20 ticks: after 3 stable ticks, key_strobe pulses once, key_pressed = 1, key_value = 4'h6. row_out stays 1101 until release.
3. Bounce, with "8" held: toggle col_in[1] low for 1 tick, high for 1 tick, then low. There is no accept until 3 consecutive low ticks; exactly one strobe; key_value = 4'h8.
4. Release bounce, with "A" accepted: column goes high for 2 ticks, low for 1, then high for 3. key_pressed stays 1 through the bounce, falls after the final 3 high ticks, and no second strobe occurs. key_value remains 4'hA after release.
5. Simultaneous keys "*" and "#" on row 3 (col_in = 1010 at row_out = 0111): key_value = 4'hE (lowest column wins).
   - Then release "*" while "#" stays held: key_pressed falls with no new strobe.
   - "#" is accepted only after the scan revisits row 3 (value 4'hF).
6. Reset asserted in the PRESSED state: outputs go immediately to reset values. After deassertion with the key still held, the key is re-accepted with one new strobe.
